// File: rtl/store_buffer.sv
// store_buffer
//   Posted-write FIFO between the MEM stage and the data-memory write port.
//   Stores arrive with lane-aligned data and strobes, are queued in order and
//   issued over a req/gnt handshake. Loads that hit a pending (or incoming)
//   store word are flagged so the hazard unit can stall them.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   st_valid/st_addr/st_wstrb/
//   st_wdata/st_ready             store push handshake from MEM stage
//   mem_req/mem_addr/mem_wstrb/
//   mem_wdata/mem_gnt             head-entry write request to memory
//   ld_valid/ld_addr/ld_hazard    load word-match check against pending stores
//   count, empty                  occupancy status
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    input  logic [AW-1:0]            st_addr,
    input  logic [3:0]               st_wstrb,
    input  logic [31:0]              st_wdata,
    output logic                     st_ready,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_addr,
    output logic [3:0]               mem_wstrb,
    output logic [31:0]              mem_wdata,
    input  logic                     mem_gnt,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hazard,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] ent_valid_q, ent_valid_d;

    logic [AW-1:0]    ent_addr_q  [DEPTH];
    logic [AW-1:0]    ent_addr_d  [DEPTH];
    logic [3:0]       ent_wstrb_q [DEPTH];
    logic [3:0]       ent_wstrb_d [DEPTH];
    logic [31:0]      ent_wdata_q [DEPTH];
    logic [31:0]      ent_wdata_d [DEPTH];

    logic push;
    logic pop;
    logic pending_hit;
    logic incoming_hit;

    // ld_addr byte offset is irrelevant: hazards are tracked per word.
    logic unused_ld_lsb;
    assign unused_ld_lsb = ^ld_addr[1:0];

    always_comb begin
        st_ready = (count_q != CW'(DEPTH));
        mem_req  = (count_q != '0);
        empty    = (count_q == '0);
        count    = count_q;

        // Zero-strobe stores complete the handshake but write nothing.
        push = st_valid && st_ready && (st_wstrb != 4'b0000);
        pop  = mem_req && mem_gnt;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        ent_addr_d  = ent_addr_q;
        ent_wstrb_d = ent_wstrb_q;
        ent_wdata_d = ent_wdata_q;
        ent_valid_d = ent_valid_q;
        // Clear before set: push and pop only share a slot when the buffer is
        // empty (no pop) or full (no push), so the order never matters in use.
        if (pop) begin
            ent_valid_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            ent_addr_d[wr_ptr_q]  = st_addr;
            ent_wstrb_d[wr_ptr_q] = st_wstrb;
            ent_wdata_d[wr_ptr_q] = st_wdata;
            ent_valid_d[wr_ptr_q] = 1'b1;
        end

        if (mem_req) begin
            mem_addr  = {ent_addr_q[rd_ptr_q][AW-1:2], 2'b00};
            mem_wstrb = ent_wstrb_q[rd_ptr_q];
            mem_wdata = ent_wdata_q[rd_ptr_q];
        end else begin
            mem_addr  = '0;
            mem_wstrb = '0;
            mem_wdata = '0;
        end

        // The head being granted this cycle still counts as pending.
        pending_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid_q[i] && (ent_addr_q[i][AW-1:2] == ld_addr[AW-1:2])) begin
                pending_hit = 1'b1;
            end
        end
        incoming_hit = push && (st_addr[AW-1:2] == ld_addr[AW-1:2]);
        ld_hazard    = ld_valid && (pending_hit || incoming_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ent_valid_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ent_valid_q <= ent_valid_d;
        end
    end

    // Entry payload is qualified by ent_valid_q/count_q, so it needs no reset.
    always_ff @(posedge clk) begin
        ent_addr_q  <= ent_addr_d;
        ent_wstrb_q <= ent_wstrb_d;
        ent_wdata_q <= ent_wdata_d;
    end

endmodule
